// File: rtl/fetch_unit.sv
// Purpose: instruction fetch stage. Holds the PC, reads the instruction memory combinationally and loads the IF/ID register.
// Latency: the instruction at PC p appears on if_instr/if_pc one cycle after the advancing edge where adr == p.
// Backpressure: stall holds all fetch state. branch_taken overrides stall and inserts a one-cycle bubble.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          MEM_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] adr,
  input  logic [31:0] Instruction,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // First byte address past the end of instruction memory.
  localparam logic [63:0] PC_LIMIT = 64'(MEM_SIZE) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [63:0] r_if_pc;
  logic [31:0] r_fetch_count;

  state_t      w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic        w_if_valid_nxt;
  logic [31:0] w_if_instr_nxt;
  logic [63:0] w_if_pc_nxt;
  logic [31:0] w_fetch_count_nxt;

  logic [63:0] w_target_aligned;
  logic        w_pc_in_range;
  logic [31:0] w_count_inc;

  // Redirect targets are forced to word alignment. Masking keeps every target bit in use.
  assign w_target_aligned = branch_target & ~64'h3;
  assign w_pc_in_range    = (r_pc < PC_LIMIT);
  assign w_count_inc      = (r_fetch_count == 32'hFFFF_FFFF) ? r_fetch_count
                                                             : r_fetch_count + 32'd1;

  // Next-state and datapath selection. Priority in RUN: redirect, then stall, then advance.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_valid_nxt    = r_if_valid;
    w_if_instr_nxt    = r_if_instr;
    w_if_pc_nxt       = r_if_pc;
    w_fetch_count_nxt = r_fetch_count;

    case (r_state)
      IDLE: begin
        // Spend one settle cycle after reset before fetching starts.
        w_if_valid_nxt = 1'b0;
        w_state_nxt    = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          w_pc_nxt       = w_target_aligned;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = RUN;
        end else if (stall) begin
          // Hold everything.
          w_state_nxt = RUN;
        end else if (w_pc_in_range) begin
          w_if_instr_nxt    = Instruction;
          w_if_pc_nxt       = r_pc;
          w_if_valid_nxt    = 1'b1;
          w_pc_nxt          = r_pc + 64'd4;
          w_fetch_count_nxt = w_count_inc;
        end else begin
          // PC ran off the end of memory. Stop here without capturing anything.
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = HALT;
        end
      end
      HALT: begin
        w_if_valid_nxt = 1'b0;
        if (branch_taken) begin
          w_pc_nxt    = w_target_aligned;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_if_valid_nxt = 1'b0;
        w_state_nxt    = IDLE;
      end
    endcase
  end

  // State and pipeline registers, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'd0;
      r_if_pc       <= 64'd0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_if_instr    <= w_if_instr_nxt;
      r_if_pc       <= w_if_pc_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign adr         = r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign halted      = (r_state == HALT);
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed self-checking bench for fetch_unit with a 16-word combinational instruction memory.
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: stall and branch_taken are driven by the directed stimulus below.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] adr;
  logic [31:0] Instruction;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        halted;
  logic [31:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_PC(64'h0), .MEM_SIZE(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .adr           (adr),
    .Instruction   (Instruction),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word i holds 32'h1000_0000 + 17*i. Out-of-range reads return DEADBEEF.
  always_comb begin
    if (adr < 64'd64) Instruction = 32'h1000_0000 + 32'(adr[5:2]) * 32'h11;
    else              Instruction = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;

    // Reset state. stall and branch_taken are asserted to confirm they are ignored under reset.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h30;
    step();
    check("rst_adr",   adr, 64'h0);
    check("rst_vld",   if_valid, 1'b0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc",    if_pc, 64'h0);
    check("rst_cnt",   fetch_count, 32'h0);
    check("rst_halt",  halted, 1'b0);
    stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    reset = 1'b1;

    // Sequential fetch: adr 0,0,4,8,12.
    step(); check("c1_adr", adr, 64'h0); check("c1_vld", if_valid, 1'b0);
    step(); check("c2_adr", adr, 64'h4); check("c2_pc", if_pc, 64'h0);
            check("c2_vld", if_valid, 1'b1); check("c2_instr", if_instr, 32'h1000_0000);
    step(); check("c3_adr", adr, 64'h8); check("c3_pc", if_pc, 64'h4);
    step(); check("c4_adr", adr, 64'hC); check("c4_pc", if_pc, 64'h8);
            check("c4_instr", if_instr, 32'h1000_0022); check("c4_cnt", fetch_count, 32'd3);

    // Stall for three cycles: everything freezes.
    stall = 1'b1;
    repeat (3) step();
    check("stl_adr", adr, 64'hC);
    check("stl_pc", if_pc, 64'h8);
    check("stl_instr", if_instr, 32'h1000_0022);
    check("stl_cnt", fetch_count, 32'd3);
    check("stl_vld", if_valid, 1'b1);
    stall = 1'b0;
    step();
    check("rel_pc", if_pc, 64'hC); check("rel_adr", adr, 64'h10);
    check("rel_instr", if_instr, 32'h1000_0033); check("rel_cnt", fetch_count, 32'd4);

    // A redirect with stall in the same cycle: the branch wins and the target is aligned.
    branch_taken = 1'b1; branch_target = 64'h2A; stall = 1'b1;
    step();
    check("br_adr", adr, 64'h28); check("br_vld", if_valid, 1'b0); check("br_cnt", fetch_count, 32'd4);
    branch_taken = 1'b0; stall = 1'b0;
    step();
    check("br2_pc", if_pc, 64'h28); check("br2_vld", if_valid, 1'b1);
    check("br2_instr", if_instr, 32'h1000_00AA); check("br2_adr", adr, 64'h2C);
    check("br2_cnt", fetch_count, 32'd5);

    // Reset asserted mid-stall.
    stall = 1'b1; reset = 1'b0;
    step();
    check("rs_adr", adr, 64'h0); check("rs_cnt", fetch_count, 32'd0);
    check("rs_vld", if_valid, 1'b0); check("rs_pc", if_pc, 64'h0);
    reset = 1'b1; stall = 1'b0;

    // Run off the end of memory: one IDLE cycle plus 16 fetches, then halt.
    repeat (17) step();
    check("end_adr", adr, 64'd64); check("end_cnt", fetch_count, 32'd16);
    check("end_pc", if_pc, 64'd60); check("end_halt", halted, 1'b0);
    step();
    check("h_halt", halted, 1'b1); check("h_vld", if_valid, 1'b0);
    check("h_adr", adr, 64'd64); check("h_cnt", fetch_count, 32'd16);
    stall = 1'b1; step(); stall = 1'b0;
    check("hs_halt", halted, 1'b1); check("hs_adr", adr, 64'd64);
    step();
    check("h2_halt", halted, 1'b1);

    // Reset while halted.
    reset = 1'b0;
    step();
    check("rh_adr", adr, 64'h0); check("rh_halt", halted, 1'b0);
    check("rh_cnt", fetch_count, 32'd0); check("rh_vld", if_valid, 1'b0);
    reset = 1'b1;

    // Halt again, then leave HALT with a redirect to 0.
    repeat (18) step();
    check("h3_halt", halted, 1'b1); check("h3_cnt", fetch_count, 32'd16);
    branch_taken = 1'b1; branch_target = 64'h0;
    step();
    check("hb_halt", halted, 1'b0); check("hb_adr", adr, 64'h0); check("hb_vld", if_valid, 1'b0);
    branch_taken = 1'b0;
    step();
    check("hb2_pc", if_pc, 64'h0); check("hb2_vld", if_valid, 1'b1);
    check("hb2_cnt", fetch_count, 32'd17); check("hb2_adr", adr, 64'h4);

    // Redirect out of range: RUN first, then HALT on the next advance with no capture.
    branch_taken = 1'b1; branch_target = 64'h103;
    step();
    check("oor_adr", adr, 64'h100); check("oor_halt", halted, 1'b0); check("oor_vld", if_valid, 1'b0);
    branch_taken = 1'b0;
    step();
    check("oor2_halt", halted, 1'b1); check("oor2_vld", if_valid, 1'b0);
    check("oor2_adr", adr, 64'h100); check("oor2_cnt", fetch_count, 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
